// File: rtl/avalon_crypto_regfile.sv
// avalon_crypto_regfile
//   Avalon-MM slave register file in front of a block-cipher core.
//   Holds key and message words, fires a one-cycle start pulse to the core,
//   captures the core result on a rising CORE_DONE, and reports sticky
//   DONE / protection / timeout status with a level interrupt.
//
// Ports
//   CLK, RESET_N            clock, asynchronous active-low reset
//   AVL_READ/WRITE/CS       Avalon-MM strobes (chip select gates both)
//   AVL_BYTE_EN             per-byte write enables
//   AVL_ADDR                word address
//   AVL_WRITEDATA           write data
//   AVL_READDATA            read data, registered (read latency 1)
//   CORE_START              one-cycle start pulse to the core
//   CORE_KEY, CORE_MSG      key / message to the core, word 0 in the MSBs
//   CORE_DONE               core completion (rising edge is used)
//   CORE_RESULT             core output, word 0 in the MSBs
//   IRQ                     registered DONE & IRQ_EN
//   EXPORT_DATA             result word 0 (LED conduit)
//
// Address map (WORDS = W): 0..W-1 KEY, W..2W-1 MSG, 2W..3W-1 RESULT (RO),
//   2**ADDR_W-2 CTRL {IRQ_EN, START}, 2**ADDR_W-1 STATUS {ERR_TMO, ERR_PROT, BUSY, DONE}.
module avalon_crypto_regfile #(
  parameter int DATA_W  = 32,
  parameter int WORDS   = 4,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 0
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      AVL_READ,
  input  logic                      AVL_WRITE,
  input  logic                      AVL_CS,
  input  logic [DATA_W/8-1:0]       AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]         AVL_ADDR,
  input  logic [DATA_W-1:0]         AVL_WRITEDATA,
  output logic [DATA_W-1:0]         AVL_READDATA,
  output logic                      CORE_START,
  output logic [WORDS*DATA_W-1:0]   CORE_KEY,
  output logic [WORDS*DATA_W-1:0]   CORE_MSG,
  input  logic                      CORE_DONE,
  input  logic [WORDS*DATA_W-1:0]   CORE_RESULT,
  output logic                      IRQ,
  output logic [DATA_W-1:0]         EXPORT_DATA
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  TMO_LIM  = CNT_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] A_CTRL   = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] A_STATUS = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BUSY} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] key_q [WORDS];
  logic [DATA_W-1:0] msg_q [WORDS];
  logic [DATA_W-1:0] res_q [WORDS];
  logic [DATA_W-1:0] rdata_q, rd_mux;
  logic [CNT_W-1:0]  tmo_cnt_q;
  logic              irq_en_q, done_q, err_prot_q, err_tmo_q, irq_q, done_prev_q;

  logic wr, rd, busy, ctrl_sel, status_sel, kmsg_sel;
  logic start_req, prot_hit, core_rise, complete, tmo_hit;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] m;
    m = old;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) m[b*8 +: 8] = wdata[b*8 +: 8];
    return m;
  endfunction

  assign wr         = AVL_WRITE & AVL_CS;
  assign rd         = AVL_READ & AVL_CS;
  assign busy       = (state_q != ST_IDLE);
  assign ctrl_sel   = (AVL_ADDR == A_CTRL);
  assign status_sel = (AVL_ADDR == A_STATUS);
  assign kmsg_sel   = (AVL_ADDR < ADDR_W'(2 * WORDS));

  // A START request is only honoured from IDLE; while running it counts as a
  // protection violation along with any KEY/MSG write.
  assign start_req = wr & ctrl_sel & AVL_BYTE_EN[0] & AVL_WRITEDATA[0] & ~busy;
  assign prot_hit  = wr & busy & (kmsg_sel | (ctrl_sel & AVL_BYTE_EN[0] & AVL_WRITEDATA[0]));

  // Edge detect: a CORE_DONE left high from an earlier run never completes a new one.
  assign core_rise = CORE_DONE & ~done_prev_q;
  assign complete  = (state_q == ST_BUSY) & core_rise;
  assign tmo_hit   = (TIMEOUT != 0) && (state_q == ST_BUSY) && !core_rise &&
                     ((tmo_cnt_q + CNT_W'(1)) == TMO_LIM);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_req) state_d = ST_START;
      ST_START: state_d = ST_BUSY;
      ST_BUSY:  if (complete || tmo_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < WORDS; i++) begin
        key_q[i] <= '0;
        msg_q[i] <= '0;
      end
    end else if (wr && !busy) begin
      for (int i = 0; i < WORDS; i++) begin
        if (AVL_ADDR == ADDR_W'(i))
          key_q[i] <= merge_bytes(key_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
        if (AVL_ADDR == ADDR_W'(WORDS + i))
          msg_q[i] <= merge_bytes(msg_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < WORDS; i++) res_q[i] <= '0;
    end else if (complete) begin
      for (int i = 0; i < WORDS; i++)
        res_q[i] <= CORE_RESULT[(WORDS-i)*DATA_W-1 -: DATA_W];
    end
  end

  // Status and control. For the sticky bits a same-cycle set beats the W1C.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_prot_q  <= 1'b0;
      err_tmo_q   <= 1'b0;
      irq_q       <= 1'b0;
      done_prev_q <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      done_prev_q <= CORE_DONE;
      irq_q       <= done_q & irq_en_q;

      if (wr && ctrl_sel && AVL_BYTE_EN[0]) irq_en_q <= AVL_WRITEDATA[1];

      if (start_req)                                                 done_q <= 1'b0;
      else if (complete)                                             done_q <= 1'b1;
      else if (wr && status_sel && AVL_BYTE_EN[0] && AVL_WRITEDATA[0]) done_q <= 1'b0;

      if (prot_hit)                                                  err_prot_q <= 1'b1;
      else if (wr && status_sel && AVL_BYTE_EN[0] && AVL_WRITEDATA[2]) err_prot_q <= 1'b0;

      if (tmo_hit)                                                   err_tmo_q <= 1'b1;
      else if (wr && status_sel && AVL_BYTE_EN[0] && AVL_WRITEDATA[3]) err_tmo_q <= 1'b0;

      if (state_q == ST_START)     tmo_cnt_q <= '0;
      else if (state_q == ST_BUSY) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end

  // Read mux sees pre-write register values, so a same-cycle read/write of
  // one address returns the old contents.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (AVL_ADDR == ADDR_W'(i))             rd_mux = key_q[i];
      if (AVL_ADDR == ADDR_W'(WORDS + i))     rd_mux = msg_q[i];
      if (AVL_ADDR == ADDR_W'(2 * WORDS + i)) rd_mux = res_q[i];
    end
    if (ctrl_sel)   rd_mux[1]   = irq_en_q;
    if (status_sel) rd_mux[3:0] = {err_tmo_q, err_prot_q, busy, done_q};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rdata_q <= '0;
    else          rdata_q <= rd ? rd_mux : '0;
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_pack
    assign CORE_KEY[(WORDS-g)*DATA_W-1 -: DATA_W] = key_q[g];
    assign CORE_MSG[(WORDS-g)*DATA_W-1 -: DATA_W] = msg_q[g];
  end

  // Decoded straight from the state so reset removes the pulse immediately.
  assign CORE_START   = (state_q == ST_START);
  assign IRQ          = irq_q;
  assign AVL_READDATA = rdata_q;
  assign EXPORT_DATA  = res_q[0];

endmodule

// File: tb/tb_avalon_crypto_regfile.sv
// Directed bench for avalon_crypto_regfile. Two instances share the bus:
// u_dut has no timeout, u_dut_tmo uses TIMEOUT=16 with CORE_DONE tied low.
module tb_avalon_crypto_regfile;

  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 4;
  localparam int BW     = WORDS * DATA_W;

  localparam logic [ADDR_W-1:0] A_CTRL = 4'd14;
  localparam logic [ADDR_W-1:0] A_STAT = 4'd15;

  localparam logic [BW-1:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BW-1:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BW-1:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              avl_read = 1'b0, avl_write = 1'b0, avl_cs = 1'b0;
  logic [3:0]        avl_be = '0;
  logic [ADDR_W-1:0] avl_addr = '0;
  logic [DATA_W-1:0] avl_wdata = '0;
  logic              core_done = 1'b0;
  logic              core_done_t = 1'b0;
  logic [BW-1:0]     core_result = '0;

  logic [DATA_W-1:0] rdata, rdata_t, export_data, export_data_t;
  logic              core_start, core_start_t, irq, irq_t;
  logic [BW-1:0]     core_key, core_msg, core_key_t, core_msg_t;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int s0;
  logic [DATA_W-1:0] d, dt;

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start) start_cnt <= start_cnt + 1;

  avalon_crypto_regfile #(.DATA_W(DATA_W), .WORDS(WORDS), .ADDR_W(ADDR_W), .TIMEOUT(0)) u_dut (
    .CLK(clk), .RESET_N(reset_n), .AVL_READ(avl_read), .AVL_WRITE(avl_write), .AVL_CS(avl_cs),
    .AVL_BYTE_EN(avl_be), .AVL_ADDR(avl_addr), .AVL_WRITEDATA(avl_wdata), .AVL_READDATA(rdata),
    .CORE_START(core_start), .CORE_KEY(core_key), .CORE_MSG(core_msg), .CORE_DONE(core_done),
    .CORE_RESULT(core_result), .IRQ(irq), .EXPORT_DATA(export_data)
  );

  avalon_crypto_regfile #(.DATA_W(DATA_W), .WORDS(WORDS), .ADDR_W(ADDR_W), .TIMEOUT(16)) u_dut_tmo (
    .CLK(clk), .RESET_N(reset_n), .AVL_READ(avl_read), .AVL_WRITE(avl_write), .AVL_CS(avl_cs),
    .AVL_BYTE_EN(avl_be), .AVL_ADDR(avl_addr), .AVL_WRITEDATA(avl_wdata), .AVL_READDATA(rdata_t),
    .CORE_START(core_start_t), .CORE_KEY(core_key_t), .CORE_MSG(core_msg_t), .CORE_DONE(core_done_t),
    .CORE_RESULT(core_result), .IRQ(irq_t), .EXPORT_DATA(export_data_t)
  );

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus tasks start and end on a falling edge.
  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v, input logic [3:0] be);
    avl_write = 1'b1; avl_cs = 1'b1; avl_addr = a; avl_wdata = v; avl_be = be;
    @(negedge clk);
    avl_write = 1'b0; avl_cs = 1'b0; avl_be = '0;
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] v, output logic [DATA_W-1:0] vt);
    avl_read = 1'b1; avl_cs = 1'b1; avl_addr = a;
    @(negedge clk);
    avl_read = 1'b0; avl_cs = 1'b0;
    v = rdata; vt = rdata_t;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_core_start", BW'(core_start), BW'(0));
    chk("rst_irq", BW'(irq), BW'(0));
    chk("rst_readdata", BW'(rdata), BW'(0));
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_rd(A_STAT, d, dt); chk("rst_status", BW'(d), BW'(0));
    bus_rd(4'd0, d, dt);   chk("rst_key0", BW'(d), BW'(0));

    // Byte merge
    bus_wr(4'd0, 32'h11223344, 4'b1111);
    bus_wr(4'd0, 32'hAABBCCDD, 4'b0101);
    bus_rd(4'd0, d, dt); chk("byte_merge", BW'(d), BW'(32'h11BB33DD));

    // Full run with the FIPS-197 AES-128 vector
    for (int i = 0; i < WORDS; i++) begin
      bus_wr(ADDR_W'(i), KEY[(WORDS-i)*DATA_W-1 -: DATA_W], 4'hF);
      bus_wr(ADDR_W'(WORDS + i), PT[(WORDS-i)*DATA_W-1 -: DATA_W], 4'hF);
    end
    chk("core_key", core_key, KEY);
    chk("core_msg", core_msg, PT);
    core_result = CT;
    s0 = start_cnt;
    bus_wr(A_CTRL, 32'h1, 4'h1);
    chk("start_pulse_hi", BW'(core_start), BW'(1));
    bus_rd(A_CTRL, d, dt); chk("ctrl_start_reads0", BW'(d), BW'(0));
    bus_rd(A_STAT, d, dt); chk("status_busy", BW'(d), BW'(2));
    repeat (47) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    bus_rd(A_STAT, d, dt); chk("status_done", BW'(d), BW'(1));
    chk("one_start_pulse", BW'(start_cnt - s0), BW'(1));
    for (int i = 0; i < WORDS; i++) begin
      bus_rd(ADDR_W'(2 * WORDS + i), d, dt);
      chk("result_word", BW'(d), BW'(CT[(WORDS-i)*DATA_W-1 -: DATA_W]));
    end
    chk("export_data", BW'(export_data), BW'(32'h69c4e0d8));

    // Protection: CORE_DONE still high from the last run must not complete this one
    s0 = start_cnt;
    bus_wr(A_CTRL, 32'h1, 4'h1);
    bus_wr(4'd4, 32'hDEADBEEF, 4'hF);
    bus_wr(A_CTRL, 32'h1, 4'h1);
    bus_rd(A_STAT, d, dt); chk("status_prot", BW'(d), BW'(6));
    bus_rd(4'd4, d, dt);   chk("msg0_protected", BW'(d), BW'(32'h00112233));
    repeat (4) @(negedge clk);
    chk("prot_single_pulse", BW'(start_cnt - s0), BW'(1));
    core_done = 1'b0;
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    bus_rd(A_STAT, d, dt); chk("status_prot_done", BW'(d), BW'(5));
    bus_wr(A_STAT, 32'h4, 4'h1);
    bus_rd(A_STAT, d, dt); chk("w1c_prot", BW'(d), BW'(1));

    // IRQ
    bus_wr(A_CTRL, 32'h2, 4'h1);
    @(negedge clk);
    chk("irq_set", BW'(irq), BW'(1));
    bus_rd(A_CTRL, d, dt); chk("ctrl_irq_en", BW'(d), BW'(2));
    bus_wr(A_STAT, 32'h1, 4'h1);
    chk("irq_lag", BW'(irq), BW'(1));
    @(negedge clk);
    chk("irq_clear", BW'(irq), BW'(0));
    core_done = 1'b0;
    bus_wr(A_CTRL, 32'h3, 4'h1);
    repeat (3) @(negedge clk);
    // W1C of DONE on the same edge as the completion
    avl_write = 1'b1; avl_cs = 1'b1; avl_addr = A_STAT; avl_wdata = 32'h1; avl_be = 4'h1;
    core_done = 1'b1;
    @(negedge clk);
    avl_write = 1'b0; avl_cs = 1'b0; avl_be = '0;
    chk("irq_one_cycle_late", BW'(irq), BW'(0));
    @(negedge clk);
    chk("irq_after_done", BW'(irq), BW'(1));
    bus_rd(A_STAT, d, dt); chk("done_set_wins", BW'(d), BW'(1));

    // Asynchronous reset during a run
    bus_wr(A_CTRL, 32'h3, 4'h1);
    chk("pre_rst_start", BW'(core_start), BW'(1));
    chk("pre_rst_irq", BW'(irq), BW'(1));
    reset_n = 1'b0;
    #1;
    chk("async_rst_start", BW'(core_start), BW'(0));
    chk("async_rst_irq", BW'(irq), BW'(0));
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_rd(A_STAT, d, dt);   chk("post_rst_status", BW'(d), BW'(0));
    bus_rd(4'd0, d, dt);     chk("post_rst_key0", BW'(d), BW'(0));
    bus_rd(4'd4, d, dt);     chk("post_rst_msg0", BW'(d), BW'(0));
    bus_rd(4'd8, d, dt);     chk("post_rst_res0", BW'(d), BW'(0));
    bus_rd(A_CTRL, d, dt);   chk("post_rst_ctrl", BW'(d), BW'(0));
    chk("post_rst_export", BW'(export_data), BW'(0));

    // Timeout on the TIMEOUT=16 instance
    core_done = 1'b0;
    bus_wr(A_CTRL, 32'h1, 4'h1);
    repeat (15) @(negedge clk);
    bus_rd(A_STAT, d, dt); chk("tmo_busy15", BW'(dt), BW'(2));
    bus_rd(A_STAT, d, dt); chk("tmo_busy16", BW'(dt), BW'(2));
    bus_rd(A_STAT, d, dt); chk("tmo_err", BW'(dt), BW'(8));
    chk("no_tmo_still_busy", BW'(d), BW'(2));
    bus_rd(4'd8, d, dt);   chk("tmo_result_kept", BW'(dt), BW'(0));
    bus_wr(A_STAT, 32'h8, 4'h1);
    bus_rd(A_STAT, d, dt); chk("tmo_w1c", BW'(dt), BW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
